// File: rtl/led_effect_engine_if.sv
// Effect-select handshake between the piano control logic and the LED effect engine.
// The requester holds effect_sel/effect_valid until it sees effect_ready.
interface led_effect_engine_if;
  logic [3:0] effect_sel;
  logic       effect_valid;
  logic       effect_ready;

  modport master (output effect_sel, output effect_valid, input effect_ready);
  modport slave  (input effect_sel, input effect_valid, output effect_ready);
endinterface

// File: rtl/led_effect_engine.sv
// PWM LED effect generator with a gain crossfade on every effect change.
// Effects are rendered per LED, scaled by the global gain, then compared against a free-running PWM counter.
module led_effect_engine #(
  parameter int NUM_LEDS   = 16,
  parameter int PWM_BITS   = 8,
  parameter int TICK_DIV   = 8192,
  parameter int FADE_STEP  = 16,
  parameter int DECAY_STEP = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  led_effect_engine_if.slave  effect,
  input  logic [NUM_LEDS-1:0] key_state,
  input  logic [15:0]         tone,
  output logic [NUM_LEDS-1:0] led_out,
  output logic [3:0]          cur_effect,
  output logic                frame_strobe
);

  localparam int PRE_W   = $clog2(TICK_DIV);
  localparam int CHASE_W = $clog2(NUM_LEDS);
  localparam logic [PWM_BITS-1:0] LVL_MAX = '1;
  localparam logic [PWM_BITS-1:0] DECAY   = PWM_BITS'(DECAY_STEP);
  localparam logic [7:0]          FADE    = 8'(FADE_STEP);
  localparam logic [4:0]          LAST    = 5'(NUM_LEDS - 1);

  typedef enum logic [1:0] {RUN, FADE_OUT, SWITCH, FADE_IN} state_t;

  state_t               state, state_next;
  logic [7:0]           gain, gain_next;
  logic [3:0]           pending, pending_next;
  logic [3:0]           cur_effect_next;
  logic                 clear_keys;
  logic                 ready;

  logic [PRE_W-1:0]     prescaler;
  logic                 tick;
  logic [7:0]           phase;
  logic [CHASE_W-1:0]   chase_pos;
  logic [15:0]          lfsr;
  logic [PWM_BITS-1:0]  pwm_cnt;

  logic [7:0]           breathe_tri;
  logic [PWM_BITS+7:0]  breathe_wide;
  logic [PWM_BITS-1:0]  breathe_lvl;
  logic [4:0]           bar_top;
  logic [8:0]           gain_p1;

  assign tick = (prescaler == PRE_W'(TICK_DIV - 1));

  // Shared timebase: tick prescaler, effect phase, chase position, sparkle LFSR and PWM counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler    <= '0;
      phase        <= '0;
      chase_pos    <= '0;
      lfsr         <= 16'hACE1;
      pwm_cnt      <= '0;
      frame_strobe <= 1'b0;
    end else begin
      pwm_cnt      <= pwm_cnt + 1'b1;
      frame_strobe <= (pwm_cnt == '0);
      lfsr         <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      if (tick) begin
        prescaler <= '0;
        phase     <= phase + 1'b1;
        if (phase[1:0] == 2'b11)
          chase_pos <= (chase_pos == CHASE_W'(NUM_LEDS - 1)) ? '0 : chase_pos + 1'b1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      gain       <= 8'hFF;
      pending    <= '0;
      cur_effect <= '0;
    end else begin
      state      <= state_next;
      gain       <= gain_next;
      pending    <= pending_next;
      cur_effect <= cur_effect_next;
    end
  end

  // Crossfade controller: a request for the effect already shown is absorbed without a fade.
  always_comb begin
    state_next      = state;
    gain_next       = gain;
    pending_next    = pending;
    cur_effect_next = cur_effect;
    clear_keys      = 1'b0;
    ready           = 1'b0;
    case (state)
      RUN: begin
        ready = 1'b1;
        if (effect.effect_valid && (effect.effect_sel != cur_effect)) begin
          pending_next = effect.effect_sel;
          state_next   = FADE_OUT;
        end
      end
      FADE_OUT: begin
        if (gain == 8'h00)
          state_next = SWITCH;
        else if (tick)
          gain_next = (gain > FADE) ? gain - FADE : 8'h00;
      end
      SWITCH: begin
        cur_effect_next = pending;
        clear_keys      = 1'b1;
        state_next      = FADE_IN;
      end
      FADE_IN: begin
        if (gain == 8'hFF)
          state_next = RUN;
        else if (tick)
          gain_next = (gain > (8'hFF - FADE)) ? 8'hFF : gain + FADE;
      end
      default: state_next = RUN;
    endcase
  end

  assign effect.effect_ready = ready;

  assign breathe_tri  = phase[7] ? ~{phase[6:0], 1'b0} : {phase[6:0], 1'b0};
  assign breathe_wide = {breathe_tri, {PWM_BITS{1'b0}}};
  assign breathe_lvl  = PWM_BITS'(breathe_wide >> 8);
  assign bar_top      = ({1'b0, tone[3:0]} > LAST) ? LAST : {1'b0, tone[3:0]};
  assign gain_p1      = {1'b0, gain} + 9'd1;

  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_led
    logic                spark;
    logic [PWM_BITS-1:0] key_level;
    logic [PWM_BITS-1:0] raw;
    logic [PWM_BITS+8:0] scaled;
    logic [PWM_BITS-1:0] out_level;
    logic                drive;

    // Per-LED state: sparkle bit snapshot on tick and the KEYS decay level.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        spark     <= 1'b0;
        key_level <= '0;
        drive     <= 1'b0;
      end else begin
        if (tick)
          spark <= lfsr[g % 16];
        if (clear_keys)
          key_level <= '0;
        else if (key_state[g])
          key_level <= LVL_MAX;
        else if (tick)
          key_level <= (key_level > DECAY) ? key_level - DECAY : '0;
        drive <= (pwm_cnt < out_level);
      end
    end

    always_comb begin
      raw = '0;
      case (cur_effect)
        4'd1:    raw = breathe_lvl;
        4'd2:    raw = (chase_pos == CHASE_W'(g)) ? LVL_MAX : '0;
        4'd3:    raw = spark ? LVL_MAX : '0;
        4'd4:    raw = key_level;
        4'd5:    raw = ((tone != 16'h0000) && (5'(g) <= bar_top)) ? LVL_MAX : '0;
        default: raw = '0;
      endcase
    end

    assign scaled     = (PWM_BITS+9)'(raw) * (PWM_BITS+9)'(gain_p1);
    assign out_level  = PWM_BITS'(scaled >> 8);
    assign led_out[g] = drive;
  end

endmodule

// File: tb/tb_led_effect_engine.sv
// Randomized bench for led_effect_engine with a cycle-level reference model
// derived from elapsed-cycle arithmetic, plus literal duty/timing checks.
module tb_led_effect_engine;

  localparam int N  = 16;
  localparam int D  = 4;
  localparam int FS = 16;
  localparam int DS = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] key_state;
  logic [15:0] tone;
  logic [15:0] led_out;
  logic [3:0]  cur_effect;
  logic        frame_strobe;
  logic [7:0]  led8;
  logic [3:0]  cur8;
  logic        strobe8;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  led_effect_engine_if bus();
  led_effect_engine_if bus8();

  assign bus8.effect_sel   = bus.effect_sel;
  assign bus8.effect_valid = bus.effect_valid;

  led_effect_engine #(.NUM_LEDS(N), .TICK_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n), .effect(bus.slave), .key_state(key_state), .tone(tone),
    .led_out(led_out), .cur_effect(cur_effect), .frame_strobe(frame_strobe)
  );

  led_effect_engine #(.NUM_LEDS(8), .TICK_DIV(D)) dut8 (
    .clk(clk), .rst_n(rst_n), .effect(bus8.slave), .key_state(key_state[7:0]), .tone(tone),
    .led_out(led8), .cur_effect(cur8), .frame_strobe(strobe8)
  );

  // Reference model state: elapsed cycles since reset and the crossfade mode (0 run, 1 out, 2 switch, 3 in).
  int          m_k, m_gain, m_mode, m_pend, m_cur, m_lfsr, m_spark;
  int          m_level[N];
  logic [15:0] exp_led;
  logic        exp_strobe;
  bit          model_ok = 1'b0;

  function automatic int lfsr_next(int s);
    int b;
    b = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
    return ((s >> 1) | (b << 15)) & 16'hFFFF;
  endfunction

  function automatic int raw_of(int i, int phase, int chase);
    int top;
    case (m_cur)
      1: return (phase < 128) ? 2 * phase : 255 - 2 * (phase - 128);
      2: return (i == chase) ? 255 : 0;
      3: return (((m_spark >> (i % 16)) & 1) != 0) ? 255 : 0;
      4: return m_level[i];
      5: begin
        if (tone == 16'h0000) return 0;
        top = int'(tone[3:0]);
        if (top > N - 1) top = N - 1;
        return (i <= top) ? 255 : 0;
      end
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) begin : ref_model
    int tk, phase, chase, pwm, lvl;
    if (!rst_n) begin
      m_k = 0; m_gain = 255; m_mode = 0; m_pend = 0; m_cur = 0;
      m_lfsr = 16'hACE1; m_spark = 0;
      for (int i = 0; i < N; i++) m_level[i] = 0;
      exp_led = '0; exp_strobe = 1'b0; model_ok = 1'b1;
    end else if (model_ok) begin
      tk    = ((m_k % D) == D - 1) ? 1 : 0;
      phase = (m_k / D) % 256;
      chase = (m_k / D / 4) % N;
      pwm   = m_k % 256;
      for (int i = 0; i < N; i++) begin
        lvl = (raw_of(i, phase, chase) * (m_gain + 1)) / 256;
        exp_led[i] = (pwm < lvl);
      end
      exp_strobe = (pwm == 0);
      for (int i = 0; i < N; i++) begin
        if (m_mode == 2) m_level[i] = 0;
        else if (key_state[i]) m_level[i] = 255;
        else if (tk == 1) m_level[i] = (m_level[i] > DS) ? m_level[i] - DS : 0;
      end
      if (tk == 1) m_spark = m_lfsr;
      case (m_mode)
        0: if (bus.effect_valid && (int'(bus.effect_sel) != m_cur)) begin
             m_pend = int'(bus.effect_sel); m_mode = 1;
           end
        1: if (m_gain == 0) m_mode = 2;
           else if (tk == 1) m_gain = (m_gain > FS) ? m_gain - FS : 0;
        2: begin m_cur = m_pend; m_mode = 3; end
        default: if (m_gain == 255) m_mode = 0;
                 else if (tk == 1) m_gain = (m_gain + FS > 255) ? 255 : m_gain + FS;
      endcase
      m_lfsr = lfsr_next(m_lfsr);
      m_k++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      checkOutput("led_out", 32'(led_out), 32'(exp_led));
      checkOutput("status{ready,cur,strobe}", 32'({bus.effect_ready, cur_effect, frame_strobe}),
                  32'({(m_mode == 0), 4'(m_cur), exp_strobe}));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] sel, input logic valid, input logic [15:0] keys,
                               input logic [15:0] tn, input int cycles);
    bus.effect_sel   = sel;
    bus.effect_valid = valid;
    key_state        = keys;
    tone             = tn;
    step(cycles);
  endtask

  task automatic waitReady();
    int n = 0;
    while (!bus.effect_ready && n < 400) begin step(1); n++; end
    if (!bus.effect_ready) checkOutput("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic requestEffect(input logic [3:0] sel);
    applyStimulus(sel, 1'b1, key_state, tone, 1);
    bus.effect_valid = 1'b0;
    waitReady();
  endtask

  int hi[N];
  int hi8[8];
  int strobes8;

  task automatic measureDuty();
    for (int i = 0; i < N; i++) hi[i] = 0;
    for (int i = 0; i < 8; i++) hi8[i] = 0;
    strobes8 = 0;
    repeat (256) begin
      step(1);
      for (int i = 0; i < N; i++) if (led_out[i]) hi[i]++;
      for (int i = 0; i < 8; i++) if (led8[i]) hi8[i]++;
      if (strobe8) strobes8++;
    end
  endtask

  initial begin
    int n;
    bus.effect_sel = 4'd0; bus.effect_valid = 1'b0;
    key_state = '0; tone = '0; rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;

    step(100);
    checkOutput("idle_led", 32'(led_out), 32'd0);
    checkOutput("idle_ready", 32'(bus.effect_ready), 32'd1);
    checkOutput("idle_cur", 32'(cur_effect), 32'd0);

    n = 0;
    while (!frame_strobe && n < 300) begin step(1); n++; end
    n = 0;
    do begin step(1); n++; end while (!frame_strobe && n < 300);
    checkOutput("strobe_period", 32'(n), 32'd256);

    // Crossfade into BREATHE and time it.
    applyStimulus(4'd1, 1'b1, 16'h0, 16'h0, 1);
    bus.effect_valid = 1'b0;
    checkOutput("ready_drops", 32'(bus.effect_ready), 32'd0);
    n = 1;
    while (!bus.effect_ready && n < 300) begin step(1); n++; end
    checkOutput("fade_length_126_129", 32'(n >= 126 && n <= 129), 32'd1);
    checkOutput("breathe_cur", 32'(cur_effect), 32'd1);

    applyStimulus(4'd1, 1'b1, 16'h0, 16'h0, 1);
    bus.effect_valid = 1'b0;
    checkOutput("same_effect_ready", 32'(bus.effect_ready), 32'd1);
    step(50);

    // KEYS: held key at full duty, released key decays to dark within 32 ticks.
    requestEffect(4'd4);
    applyStimulus(4'd4, 1'b0, 16'h0001, 16'h0, 4);
    measureDuty();
    checkOutput("key0_held_duty", 32'(hi[0]), 32'd255);
    checkOutput("key1_idle_duty", 32'(hi[1]), 32'd0);
    applyStimulus(4'd4, 1'b0, 16'h0000, 16'h0, 33 * D + 4);
    measureDuty();
    checkOutput("key0_decayed_duty", 32'(hi[0]), 32'd0);

    // BAR on both widths.
    tone = 16'h0003;
    requestEffect(4'd5);
    measureDuty();
    for (int i = 0; i < N; i++)
      checkOutput($sformatf("bar3_led%0d", i), 32'(hi[i]), (i <= 3) ? 32'd255 : 32'd0);
    tone = 16'h000F;
    measureDuty();
    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("bar8_led%0d", i), 32'(hi8[i]), 32'd255);
    checkOutput("bar8_cur", 32'(cur8), 32'd5);
    checkOutput("bar8_strobes", 32'(strobes8), 32'd1);
    checkOutput("bar8_ready", 32'(bus8.effect_ready), 32'd1);

    // Reset in the middle of a fade-out.
    applyStimulus(4'd2, 1'b1, 16'h0, 16'h0003, 1);
    bus.effect_valid = 1'b0;
    step(20);
    checkOutput("midfade_busy", 32'(bus.effect_ready), 32'd0);
    rst_n = 1'b0;
    step(1);
    checkOutput("rst_ready", 32'(bus.effect_ready), 32'd1);
    checkOutput("rst_cur", 32'(cur_effect), 32'd0);
    checkOutput("rst_led", 32'(led_out), 32'd0);
    rst_n = 1'b1;
    step(10);

    // Random traffic; valid pulses during fades must be ignored.
    for (int it = 0; it < 30; it++) begin
      applyStimulus(4'($urandom_range(0, 15)), 1'b1, 16'($urandom), 16'($urandom_range(0, 31)),
                    $urandom_range(1, 3));
      bus.effect_valid = 1'b0;
      n = $urandom_range(10, 250);
      repeat (n) begin
        if ($urandom_range(0, 15) == 0) begin
          key_state = 16'($urandom);
          tone      = 16'($urandom_range(0, 20));
        end
        step(1);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
